// File: rtl/matmul_index_sequencer.sv
// Purpose: steps index_A/index_B through a diagonal or full row-major schedule for the matmul datapath, then captures Answer.
// Latency: start sampled on E0, first pair after E1, done after E(1 + pairs*HOLD + DRAIN_CYC).
// Backpressure: none; start is honoured only in IDLE, abort cancels LOAD/SWEEP/DRAIN on the next edge.
module matmul_index_sequencer #(
    parameter int DATA_W    = 1024,
    parameter int IDX_W     = 5,
    parameter int HOLD      = 1,
    parameter int DRAIN_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] A_wire,
    output logic [DATA_W-1:0] B_wire,
    output logic [IDX_W-1:0]  index_A,
    output logic [IDX_W-1:0]  index_B,
    input  logic [DATA_W-1:0] Answer,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              result_valid
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SWEEP = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // One counter serves both the per-pair hold and the drain wait.
    localparam int CNT_W = (($clog2(HOLD) > $clog2(DRAIN_CYC)) ? $clog2(HOLD) : $clog2(DRAIN_CYC)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX    = '1;
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             mode_q;
    logic             accept;
    logic             capture;
    logic             last_pair;

    assign accept    = (state == S_IDLE) && start && !abort;
    assign capture   = (state == S_DRAIN) && !abort && (cnt == DRAIN_LAST);
    // Both modes finish on (max,max); diagonal keeps index_B equal to index_A.
    assign last_pair = (index_A == IDX_MAX) && (index_B == IDX_MAX);

    assign busy = (state == S_LOAD) || (state == S_SWEEP) || (state == S_DRAIN);
    assign done = (state == S_DONE);

    // Control: state, hold/drain counter and the index schedule.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            index_A <= '0;
            index_B <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) state <= S_LOAD;
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= abort ? S_IDLE : S_SWEEP;
                end
                S_SWEEP: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        cnt     <= '0;
                        index_A <= '0;
                        index_B <= '0;
                    end else if (cnt != HOLD_LAST) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        cnt <= '0;
                        if (last_pair) begin
                            // Indices stay on the last pair through DRAIN.
                            state <= S_DRAIN;
                        end else if (!mode_q) begin
                            index_A <= index_A + IDX_ONE;
                            index_B <= index_B + IDX_ONE;
                        end else if (index_B == IDX_MAX) begin
                            index_A <= index_A + IDX_ONE;
                            index_B <= '0;
                        end else begin
                            index_B <= index_B + IDX_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort || capture) begin
                        state   <= abort ? S_IDLE : S_DONE;
                        cnt     <= '0;
                        index_A <= '0;
                        index_B <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state   <= S_IDLE;
                    cnt     <= '0;
                    index_A <= '0;
                    index_B <= '0;
                end
            endcase
        end
    end

    // Operand/mode latch on an accepted start; result capture at the end of DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            A_wire       <= '0;
            B_wire       <= '0;
            mode_q       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (accept) begin
            A_wire       <= a_in;
            B_wire       <= b_in;
            mode_q       <= mode;
            result_valid <= 1'b0;
        end else if (capture) begin
            result       <= Answer;
            result_valid <= 1'b1;
        end
    end

endmodule
